// File: rtl/ntt_ctrl_gen.sv
// ntt_ctrl_gen: address/twiddle/enable sequencer for a dual-butterfly NTT engine.
// Walks NTT (CT), INTT (GS) or pointwise passes, N/4 read cycles per pass,
// followed by a PIPE_LAT-cycle drain so every write lands before the next pass.
// Optional feature macro: NTT_CTRL_SCALE_EN appends a scale pass (op=11) to INTT.
module ntt_ctrl_gen #(
  parameter int LOG_N    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [3:0]           stage_max,
  output logic [1:0]           op,
  output logic [3:0]           stage,
  output logic [4*LOG_N-1:0]   raddr,
  output logic [4*LOG_N-1:0]   waddr,
  output logic [LOG_N-1:0]     tw0,
  output logic [LOG_N-1:0]     tw1,
  output logic                 ren,
  output logic                 wen,
  output logic                 special_add,
  output logic [2:0]           cur_state,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = LOG_N - 2;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    RUN   = 3'b001,
    DRAIN = 3'b010,
    DONE  = 3'b011
  } state_t;

  localparam logic [1:0] OP_CT = 2'b00;
  localparam logic [1:0] OP_GS = 2'b01;
  localparam logic [1:0] OP_PW = 2'b10;
  localparam logic [1:0] OP_SC = 2'b11;

  localparam logic [CW-1:0] C_LAST = {CW{1'b1}};
  localparam logic [3:0]    S_TOP  = 4'(LOG_N - 1);
  localparam logic [3:0]    D_LAST = 4'(PIPE_LAT - 1);

  // Insert a zero bit at position k of j: a = (j/len)*2*len + j%len with len = 1<<k.
  function automatic logic [LOG_N-1:0] ins_zero(input logic [LOG_N-1:0] j, input int k);
    logic [31:0] jj;
    logic [31:0] lo;
    logic [31:0] hi;
    jj = 32'(j);
    lo = jj & ((32'd1 << k) - 32'd1);
    hi = (jj >> k) << (k + 1);
    return LOG_N'(hi | lo);
  endfunction

  // Butterfly address pair {b, a} with b = a + (1<<k).
  function automatic logic [2*LOG_N-1:0] bfly(input logic [LOG_N-1:0] j, input int k);
    logic [LOG_N-1:0] a;
    a = ins_zero(j, k);
    return {LOG_N'(32'(a) | (32'd1 << k)), a};
  endfunction

  // Twiddle index (1<<base_sh) + (j>>j_sh).
  function automatic logic [LOG_N-1:0] twf(input logic [LOG_N-1:0] j, input int base_sh, input int j_sh);
    return LOG_N'((32'd1 << base_sh) + (32'(j) >> j_sh));
  endfunction

  state_t            state_r, state_n;
  logic [CW-1:0]     c_r, c_n;
  logic [3:0]        stage_r, stage_n;
  logic [1:0]        op_r, op_n;
  logic [3:0]        dcnt_r, dcnt_n;
  logic [3:0]        last_r, last_n;

  logic [4*LOG_N-1:0] raddr_s, raddr_r;
  logic [LOG_N-1:0]   tw0_s, tw1_s, tw0_r, tw1_r;
  logic [LOG_N-1:0]   j0_s, j1_s;
  int                 s_i;
  logic               ren_r, busy_r, done_r;

  logic               en_sh_r   [PIPE_LAT];
  logic [4*LOG_N-1:0] addr_sh_r [PIPE_LAT];

  // Next-state logic: pass sequencing, cycle counter wrap and drain timing.
  always_comb begin
    state_n = state_r;
    c_n     = c_r;
    stage_n = stage_r;
    op_n    = op_r;
    dcnt_n  = dcnt_r;
    last_n  = last_r;
    case (state_r)
      IDLE: begin
        if (start && (mode == 3'b001 || mode == 3'b010 || mode == 3'b011)) begin
          state_n = RUN;
          c_n     = '0;
          stage_n = 4'd0;
          dcnt_n  = 4'd0;
          if (mode == 3'b011) begin
            op_n   = OP_PW;
            last_n = 4'd0;
          end else begin
            op_n   = (mode == 3'b001) ? OP_CT : OP_GS;
            last_n = (stage_max > S_TOP) ? S_TOP : stage_max;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (c_r == C_LAST) begin
          state_n = DRAIN;
          c_n     = '0;
          dcnt_n  = 4'd0;
        end else begin
          c_n = c_r + CW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_r == D_LAST) begin
          if ((op_r == OP_CT || op_r == OP_GS) && stage_r < last_r) begin
            state_n = RUN;
            stage_n = stage_r + 4'd1;
            c_n     = '0;
          end
`ifdef NTT_CTRL_SCALE_EN
          else if (op_r == OP_GS) begin
            state_n = RUN;
            op_n    = OP_SC;
            stage_n = 4'd0;
            c_n     = '0;
          end
`endif
          else begin
            state_n = DONE;
          end
        end else begin
          dcnt_n = dcnt_r + 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Address and twiddle generation for the cycle about to be registered.
  always_comb begin
    raddr_s = '0;
    tw0_s   = '0;
    tw1_s   = '0;
    j0_s    = {1'b0, c_n, 1'b0};
    j1_s    = {1'b0, c_n, 1'b1};
    s_i     = int'(stage_n);
    if (state_n == RUN) begin
      case (op_n)
        OP_CT: begin
          raddr_s = {bfly(j1_s, LOG_N - 1 - s_i), bfly(j0_s, LOG_N - 1 - s_i)};
          tw0_s   = twf(j0_s, s_i, LOG_N - 1 - s_i);
          tw1_s   = twf(j1_s, s_i, LOG_N - 1 - s_i);
        end
        OP_GS: begin
          raddr_s = {bfly(j1_s, s_i), bfly(j0_s, s_i)};
          tw0_s   = twf(j0_s, LOG_N - 1 - s_i, s_i);
          tw1_s   = twf(j1_s, LOG_N - 1 - s_i, s_i);
        end
        OP_PW, OP_SC: begin
          raddr_s = {c_n, 2'b11, c_n, 2'b10, c_n, 2'b01, c_n, 2'b00};
        end
        default: begin
          raddr_s = '0;
        end
      endcase
    end else begin
      raddr_s = '0;
    end
  end

  // FSM state and pass bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      c_r     <= '0;
      stage_r <= 4'd0;
      op_r    <= 2'b00;
      dcnt_r  <= 4'd0;
      last_r  <= 4'd0;
    end else begin
      state_r <= state_n;
      c_r     <= c_n;
      stage_r <= stage_n;
      op_r    <= op_n;
      dcnt_r  <= dcnt_n;
      last_r  <= last_n;
    end
  end

  // Registered read-side outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_r <= '0;
      tw0_r   <= '0;
      tw1_r   <= '0;
      ren_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      raddr_r <= raddr_s;
      tw0_r   <= tw0_s;
      tw1_r   <= tw1_s;
      ren_r   <= (state_n == RUN);
      busy_r  <= (state_n != IDLE);
      done_r  <= (state_n == DONE);
    end
  end

  // Write-side delay line: wen/waddr trail ren/raddr by PIPE_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        en_sh_r[i]   <= 1'b0;
        addr_sh_r[i] <= '0;
      end
    end else begin
      en_sh_r[0]   <= ren_r;
      addr_sh_r[0] <= raddr_r;
      for (int i = 1; i < PIPE_LAT; i++) begin
        en_sh_r[i]   <= en_sh_r[i-1];
        addr_sh_r[i] <= addr_sh_r[i-1];
      end
    end
  end

`ifdef NTT_CTRL_SCALE_EN
  logic sa_r;

  // Scale-pass flag, high on every read cycle of the appended scale pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_r <= 1'b0;
    end else begin
      sa_r <= (state_n == RUN) && (op_n == OP_SC);
    end
  end

  assign special_add = sa_r;
`else
  assign special_add = 1'b0;
`endif

  assign op        = op_r;
  assign stage     = stage_r;
  assign raddr     = raddr_r;
  assign waddr     = addr_sh_r[PIPE_LAT-1];
  assign tw0       = tw0_r;
  assign tw1       = tw1_r;
  assign ren       = ren_r;
  assign wen       = en_sh_r[PIPE_LAT-1];
  assign cur_state = state_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: doc/ntt_ctrl_gen.md
NTT_CTRL_GEN -- requirements
Module: ntt_ctrl_gen

Interface
REQ-001 SHALL have parameter LOG_N, default 8, log2 of the polynomial length N (N = 2^LOG_N, LOG_N 3..11).
REQ-002 SHALL have parameter PIPE_LAT, default 4, butterfly read-to-write latency in cycles (1..15).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  launches a pass sequence; sampled only in IDLE.
REQ-006 mode  input  3  000 none, 001 NTT, 010 INTT, 011 pointwise, other values reserved.
REQ-007 stage_max  input  4  index of last stage for NTT/INTT; latched at start.
REQ-008 op  output  2  00 CT butterfly, 01 GS butterfly, 10 pointwise multiply, 11 scale.
REQ-009 stage  output  4  current stage index s.
REQ-010 raddr  output  4*LOG_N  packed {b1,a1,b0,a0} read addresses for the two butterfly units.
REQ-011 waddr  output  4*LOG_N  raddr delayed PIPE_LAT cycles.
REQ-012 tw0, tw1  output  LOG_N each  twiddle ROM index for unit 0 and unit 1.
REQ-013 ren, wen  output  1 each  read enable; write enable (ren delayed PIPE_LAT cycles).
REQ-014 special_add  output  1  high on cycles that issue scale-pass reads.
REQ-015 cur_state  output  3  FSM state: 000 IDLE, 001 RUN, 010 DRAIN, 011 DONE.
REQ-016 busy, done  output  1 each  busy = state not IDLE; done = one-cycle pulse in DONE.

Function
REQ-017 All outputs SHALL be registered; a start sampled at edge t SHALL put the FSM in RUN with the first ren at cycle t+1.
REQ-018 start SHALL be ignored when busy, and when mode is 000 or reserved (FSM stays IDLE).
REQ-019 Latched stage_max SHALL saturate to LOG_N-1; NTT/INTT run stages s = 0..stage_max, pointwise runs one pass with stage=0.
REQ-020 Each pass SHALL hold RUN for N/4 cycles, cycle counter c = 0..N/4-1, ren=1, unit u using butterfly j = 2c+u.
REQ-021 NTT (op=00): len = N>>(s+1), a = (j/len)*2*len + j%len, b = a+len, tw = (1<<s) + (j>>(LOG_N-1-s)).
REQ-022 INTT (op=01): len = 1<<s, same a/b formula, tw = (1<<(LOG_N-1-s)) + (j>>s).
REQ-023 Pointwise (op=10): a0=4c, b0=4c+1, a1=4c+2, b1=4c+3, tw0=tw1=0.
REQ-024 After the last RUN cycle of every pass the FSM SHALL enter DRAIN for exactly PIPE_LAT cycles (ren=0), so all writes land before the next pass reads.
REQ-025 After DRAIN: next pass RUN if one remains, else DONE for one cycle (done=1), then IDLE.
REQ-026 wen/waddr SHALL be a PIPE_LAT-deep shift of ren/raddr; wen count SHALL equal ren count per pass.
REQ-027 Counters SHALL wrap c at N/4-1 with no extra cycle; addresses SHALL never exceed N-1.

Reset
REQ-028 rst SHALL force IDLE, clear c, stage, op, raddr, waddr, tw0, tw1, all enables, special_add, busy, done to 0, and flush the wen shift register, including mid-pass (no wen after rst).
REQ-029 rst and start on the same edge: rst SHALL win.

Configuration
REQ-030 With macro NTT_CTRL_SCALE_EN defined, INTT SHALL append one scale pass (op=11, pointwise addressing, tw=0, special_add=1 during its RUN) after the last stage, before DONE.
REQ-031 Without NTT_CTRL_SCALE_EN, INTT SHALL end after stage stage_max, and special_add SHALL be tied 0.

Verification
REQ-032 LOG_N=8, PIPE_LAT=4, NTT, stage_max=7: first RUN cycle a0=0,b0=128,a1=1,b1=129,tw0=tw1=1; stage 7 c=0: a0=0,b0=1,a1=2,b1=3,tw0=128,tw1=129; done at cycle 545 after start edge.
REQ-033 INTT stage_max=7, macro off: stage 0 c=0 tw0=128,tw1=129, a0=0,b0=1; done at cycle 545; macro on: 9th pass with op=11, special_add high 64 cycles, done at cycle 613.
REQ-034 Pointwise: 64 ren cycles, c=5 gives raddr {23,22,21,20}; wen first high 4 cycles after first ren; done at cycle 69.
REQ-035 stage_max=12 with LOG_N=8 -> runs 8 stages; start pulsed while busy -> ignored; mode=111 -> stays IDLE, busy=0.
REQ-036 rst asserted in stage 3 RUN: next cycle all outputs 0, cur_state=000, wen never asserts afterwards; new start works normally.
